// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the VGA timing generator and for the
// overlay/graphics stages that consume its coordinates.
//   - COORD_W / coord_t : coordinate width used by every stage
//   - DEF_*             : 640x480@60 Hz segment defaults and derived totals
//   - vga_flags_t       : the three delayed timing flags, with reset value
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Sync windows are inclusive ranges that start after the front porch.
    function automatic int sync_start(input int display, input int front);
        return display + front;
    endfunction

    function automatic int sync_end(input int display, input int front, input int sync);
        return display + front + sync - 1;
    endfunction

    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_PIPE_DLY = 1;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = sync_start(DEF_H_DISPLAY, DEF_H_FRONT);
    localparam int DEF_H_SYNC_END   = sync_end(DEF_H_DISPLAY, DEF_H_FRONT, DEF_H_SYNC);
    localparam int DEF_V_SYNC_START = sync_start(DEF_V_DISPLAY, DEF_V_FRONT);
    localparam int DEF_V_SYNC_END   = sync_end(DEF_V_DISPLAY, DEF_V_FRONT, DEF_V_SYNC);

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } vga_flags_t;

    localparam int FLAG_W = $bits(vga_flags_t);

    // Syncs idle high (inactive), blanking asserted.
    localparam vga_flags_t FLAGS_RESET = '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle of timing outputs from the generator to downstream stages.
//   p_tick     : pixel enable, one clk wide
//   pix_x/y    : current scan coordinates
//   hsync/vsync: active-low syncs, aligned with the font-ROM stage
//   video_on   : visible-area flag, aligned with the font-ROM stage
//   frame_tick : one-clk end-of-frame pulse
// master = generator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t pix_x;
    coord_t pix_y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   frame_tick;

    modport master (
        output p_tick, pix_x, pix_y, hsync, vsync, video_on, frame_tick
    );

    modport slave (
        input p_tick, pix_x, pix_y, hsync, vsync, video_on, frame_tick
    );

endinterface

// File: rtl/vga_flag_delay.sv
// ---------------------------------------------------------------------------
// vga_flag_delay
// DEPTH-stage shift register that advances only when en is high. Every
// stage resets to RESET_VAL so the output is well defined before the
// first real value has travelled through.
//   clk, reset : clock and synchronous active-high reset
//   en         : shift enable (pixel tick)
//   din        : value entering stage 0
//   dout       : last stage (registered)
// ---------------------------------------------------------------------------
module vga_flag_delay #(
    parameter int               WIDTH     = 3,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Enable-gated shift chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= RESET_VAL;
            end
        end else if (en) begin
            stage_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign dout = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// VGA scan timing: a clock divider produces the pixel enable, horizontal and
// vertical counters give raw coordinates, and the sync/visible flags are
// decoded from the counts and then delayed PIPE_DLY pixel ticks so they line
// up with the character generator's synchronous font-ROM output.
//   clk   : system clock (single domain)
//   reset : synchronous, active high
//   vga   : timing outputs (p_tick, pix_x, pix_y, hsync, vsync, video_on,
//           frame_tick), all driven straight from registers
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int PIPE_DLY  = DEF_PIPE_DLY
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_DIV - 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam coord_t COORD_ONE = coord_t'(1);
    localparam coord_t H_LAST    = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST    = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS     = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS     = coord_t'(V_DISPLAY);
    localparam coord_t H_SYNC_LO = coord_t'(sync_start(H_DISPLAY, H_FRONT));
    localparam coord_t H_SYNC_HI = coord_t'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
    localparam coord_t V_SYNC_LO = coord_t'(sync_start(V_DISPLAY, V_FRONT));
    localparam coord_t V_SYNC_HI = coord_t'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));

    logic [DIV_W-1:0] div_cnt_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic             p_tick_r;
    logic             p_tick_nxt_s;
    coord_t           h_cnt_r;
    coord_t           v_cnt_r;
    logic             frame_tick_r;
    logic             h_last_s;
    logic             v_last_s;
    vga_flags_t       flags_raw_s;
    vga_flags_t       flags_dly_s;

    // Divider next count; p_tick is looked ahead one clk so that the
    // registered tick is high exactly while div_cnt sits at CLK_DIV-1.
    always_comb begin
        div_nxt_s    = div_cnt_r;
        p_tick_nxt_s = 1'b0;
        if (div_cnt_r == DIV_LAST) begin
            div_nxt_s = '0;
        end else begin
            div_nxt_s = div_cnt_r + DIV_ONE;
        end
        if (div_cnt_r == DIV_PRE) begin
            p_tick_nxt_s = 1'b1;
        end else begin
            p_tick_nxt_s = 1'b0;
        end
    end

    // Divider count and pixel-enable register
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_r <= '0;
            p_tick_r  <= 1'b0;
        end else begin
            div_cnt_r <= div_nxt_s;
            p_tick_r  <= p_tick_nxt_s;
        end
    end

    // Wrap detection and raw flag decode from the current counts
    always_comb begin
        h_last_s             = (h_cnt_r == H_LAST);
        v_last_s             = (v_cnt_r == V_LAST);
        flags_raw_s          = FLAGS_RESET;
        flags_raw_s.video_on = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
        flags_raw_s.hsync    = !((h_cnt_r >= H_SYNC_LO) && (h_cnt_r <= H_SYNC_HI));
        flags_raw_s.vsync    = !((v_cnt_r >= V_SYNC_LO) && (v_cnt_r <= V_SYNC_HI));
    end

    // Scan counters and end-of-frame pulse; the pulse lands in the clk
    // where the counts already read (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_r      <= '0;
            v_cnt_r      <= '0;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= p_tick_r & h_last_s & v_last_s;
            if (p_tick_r) begin
                if (h_last_s) begin
                    h_cnt_r <= '0;
                    if (v_last_s) begin
                        v_cnt_r <= '0;
                    end else begin
                        v_cnt_r <= v_cnt_r + COORD_ONE;
                    end
                end else begin
                    h_cnt_r <= h_cnt_r + COORD_ONE;
                end
            end
        end
    end

    // Flags for pixel (x,y) are captured on the tick that leaves (x,y), so a
    // depth of PIPE_DLY gives exactly PIPE_DLY ticks of lag.
    vga_flag_delay #(
        .WIDTH     (FLAG_W),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (FLAGS_RESET)
    ) u_flag_delay (
        .clk   (clk),
        .reset (reset),
        .en    (p_tick_r),
        .din   (flags_raw_s),
        .dout  (flags_dly_s)
    );

    assign vga.p_tick     = p_tick_r;
    assign vga.pix_x      = h_cnt_r;
    assign vga.pix_y      = v_cnt_r;
    assign vga.hsync      = flags_dly_s.hsync;
    assign vga.vsync      = flags_dly_s.vsync;
    assign vga.video_on   = flags_dly_s.video_on;
    assign vga.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generator instances share clk/reset:
//   u_def   : default 640x480 timing, CLK_DIV=4, PIPE_DLY=1
//   u_small : shrunken 30x17 raster so whole frames fit in a short run
//   u_p3    : default raster, CLK_DIV=2, PIPE_DLY=3
// Expected outputs come from a closed-form model of clocks-since-reset.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic   p_tick;
        coord_t x;
        coord_t y;
        logic   hs;
        logic   vs;
        logic   von;
        logic   ft;
    } obs_t;

    typedef struct packed {
        int d;  int pd;
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
    } geom_t;

    localparam geom_t G_DEF = '{d:4, pd:1, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33};
    localparam geom_t G_S   = '{d:4, pd:1, hd:16,  hf:4,  hs:6,  hb:4,  vd:10,  vf:2,  vs:2, vb:3};
    localparam geom_t G_P3  = '{d:2, pd:3, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33};

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    obs_t exp_q[$];

    vga_timing_gen_if if_def();
    vga_timing_gen_if if_small();
    vga_timing_gen_if if_p3();

    vga_timing_gen u_def (.clk(clk), .reset(reset), .vga(if_def));

    vga_timing_gen #(
        .CLK_DIV(4), .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .PIPE_DLY(1)
    ) u_small (.clk(clk), .reset(reset), .vga(if_small));

    vga_timing_gen #(.CLK_DIV(2), .PIPE_DLY(3)) u_p3 (.clk(clk), .reset(reset), .vga(if_p3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs t clks after the last reset-high edge.
    function automatic obs_t model(geom_t g, int t);
        obs_t e;
        int ht, vt, n, m, fx, fy;
        ht = g.hd + g.hf + g.hs + g.hb;
        vt = g.vd + g.vf + g.vs + g.vb;
        n  = t / g.d;
        e.p_tick = ((t % g.d) == g.d - 1);
        e.x = 10'(n % ht);
        e.y = 10'((n / ht) % vt);
        if (n >= g.pd) begin
            m  = n - g.pd;
            fx = m % ht;
            fy = (m / ht) % vt;
            e.von = (fx < g.hd) && (fy < g.vd);
            e.hs  = !((fx >= g.hd + g.hf) && (fx < g.hd + g.hf + g.hs));
            e.vs  = !((fy >= g.vd + g.vf) && (fy < g.vd + g.vf + g.vs));
        end else begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.von = 1'b0;
        end
        e.ft = ((t % g.d) == 0) && (n > 0) && ((n % (ht * vt)) == 0);
        return e;
    endfunction

    function automatic obs_t sample(int which);
        obs_t o;
        if (which == 0)
            o = {if_def.p_tick, if_def.pix_x, if_def.pix_y, if_def.hsync, if_def.vsync, if_def.video_on, if_def.frame_tick};
        else if (which == 1)
            o = {if_small.p_tick, if_small.pix_x, if_small.pix_y, if_small.hsync, if_small.vsync, if_small.video_on, if_small.frame_tick};
        else
            o = {if_p3.p_tick, if_p3.pix_x, if_p3.pix_y, if_p3.hsync, if_p3.vsync, if_p3.video_on, if_p3.frame_tick};
        return o;
    endfunction

    // Leaves the bench #1 after the last reset-high edge (t = 0).
    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        int first_pt = -1;
        int n_pt = 0;
        apply_reset();
        got = sample(0);
        checks++;
        if (got.hs !== 1'b1 || got.vs !== 1'b1 || got.von !== 1'b0 || got.x !== 10'd0 || got.p_tick !== 1'b0)
            begin errors++; $display("FAIL reset_state got %h exp hs=1 vs=1 von=0 x=0 p=0", got); end
        for (int t = 0; t < 16; t++) begin
            exp_q.push_back(model(G_DEF, t));
            got = sample(0);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL reset_seq t=%0d got %h exp %h", t, got, exp); end
            if (got.p_tick) begin
                n_pt++;
                if (first_pt < 0) first_pt = t;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (first_pt != 3) begin errors++; $display("FAIL first_p_tick got %0d exp 3", first_pt); end
        checks++;
        if (n_pt != 4) begin errors++; $display("FAIL p_tick_count got %0d exp 4", n_pt); end
    endtask

    task automatic test_horizontal();
        obs_t got, exp, prev;
        int t_x640 = -1, t_von = -1, t_x656 = -1, t_hsf = -1, t_x752 = -1, t_hsr = -1;
        int lines = 0;
        apply_reset();
        prev = sample(0);
        for (int t = 0; t < 6600; t++) begin
            exp_q.push_back(model(G_DEF, t));
            got = sample(0);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL horiz t=%0d got %h exp %h", t, got, exp); end
            if (t > 0) begin
                if (t_x640 < 0 && prev.x == 10'd639 && got.x == 10'd640) t_x640 = t;
                if (t_x656 < 0 && prev.x == 10'd655 && got.x == 10'd656) t_x656 = t;
                if (t_x752 < 0 && prev.x == 10'd751 && got.x == 10'd752) t_x752 = t;
                if (t_von < 0 && prev.von && !got.von) t_von = t;
                if (t_hsf < 0 && prev.hs && !got.hs) t_hsf = t;
                if (t_hsr < 0 && !prev.hs && got.hs) t_hsr = t;
                if (prev.x == 10'd799 && got.x == 10'd0) begin
                    lines++;
                    checks++;
                    if (got.y !== 10'(lines)) begin errors++; $display("FAIL h_wrap_y got %0d exp %0d", got.y, lines); end
                end
            end
            prev = got;
            @(posedge clk); #1;
        end
        checks++;
        if (t_von - t_x640 != 4) begin errors++; $display("FAIL von_fall_lag got %0d exp 4", t_von - t_x640); end
        checks++;
        if (t_hsf - t_x656 != 4) begin errors++; $display("FAIL hsync_fall_lag got %0d exp 4", t_hsf - t_x656); end
        checks++;
        if (t_hsr - t_x752 != 4) begin errors++; $display("FAIL hsync_rise_lag got %0d exp 4", t_hsr - t_x752); end
        checks++;
        if (lines != 2) begin errors++; $display("FAIL line_wraps got %0d exp 2", lines); end
    endtask

    task automatic test_vertical();
        obs_t got, exp, prev;
        int vs_low = 0, vs_falls = 0, vwraps = 0, t_y12 = -1, t_vsf = -1;
        apply_reset();
        prev = sample(1);
        for (int t = 0; t < 2100; t++) begin
            exp_q.push_back(model(G_S, t));
            got = sample(1);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL vert t=%0d got %h exp %h", t, got, exp); end
            if (!got.vs) vs_low++;
            if (t > 0) begin
                if (prev.vs && !got.vs) begin
                    vs_falls++;
                    if (t_vsf < 0) t_vsf = t;
                end
                if (t_y12 < 0 && prev.y == 10'd11 && got.y == 10'd12) t_y12 = t;
                if (prev.y == 10'd16 && got.y == 10'd0) begin
                    vwraps++;
                    checks++;
                    if (got.x !== 10'd0) begin errors++; $display("FAIL v_wrap_x got %0d exp 0", got.x); end
                end
            end
            prev = got;
            @(posedge clk); #1;
        end
        checks++;
        if (vs_low != 240) begin errors++; $display("FAIL vsync_low_clks got %0d exp 240", vs_low); end
        checks++;
        if (vs_falls != 1) begin errors++; $display("FAIL vsync_pulses got %0d exp 1", vs_falls); end
        checks++;
        if (t_vsf - t_y12 != 4) begin errors++; $display("FAIL vsync_lag got %0d exp 4", t_vsf - t_y12); end
        checks++;
        if (vwraps != 1) begin errors++; $display("FAIL v_wraps got %0d exp 1", vwraps); end
    endtask

    task automatic test_frame();
        obs_t got, exp;
        int nft = 0;
        int t_ft[2] = '{-1, -1};
        apply_reset();
        for (int t = 0; t < 4100; t++) begin
            exp_q.push_back(model(G_S, t));
            got = sample(1);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL frame t=%0d got %h exp %h", t, got, exp); end
            if (got.ft) begin
                if (nft < 2) t_ft[nft] = t;
                nft++;
                checks++;
                if (got.x !== 10'd0 || got.y !== 10'd0) begin
                    errors++; $display("FAIL ft_at_origin got x=%0d y=%0d exp 0,0", got.x, got.y);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (nft != 2) begin errors++; $display("FAIL ft_count got %0d exp 2", nft); end
        checks++;
        if (t_ft[0] != 2040) begin errors++; $display("FAIL ft_first got %0d exp 2040", t_ft[0]); end
        checks++;
        if (t_ft[1] - t_ft[0] != 2040) begin errors++; $display("FAIL ft_period got %0d exp 2040", t_ft[1] - t_ft[0]); end
    endtask

    // Reset once mid-frame at (10,5) and once on the final tick of the frame.
    task automatic test_mid_reset();
        obs_t got, exp;
        int target;
        for (int k = 0; k < 2; k++) begin
            target = (k == 0) ? 641 : 2039;
            apply_reset();
            for (int t = 0; t <= target; t++) begin
                exp_q.push_back(model(G_S, t));
                got = sample(1);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL mid_run t=%0d got %h exp %h", t, got, exp); end
                if (t == target) reset = 1'b1;
                @(posedge clk); #1;
            end
            for (int h = 0; h < 3; h++) begin
                exp_q.push_back(model(G_S, 0));
                got = sample(1);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL mid_hold k=%0d h=%0d got %h exp %h", k, h, got, exp); end
                checks++;
                if (got.ft !== 1'b0) begin errors++; $display("FAIL mid_no_ft k=%0d got %b exp 0", k, got.ft); end
                if (h == 2) reset = 1'b0;
                @(posedge clk); #1;
            end
            for (int t = 1; t < 200; t++) begin
                exp_q.push_back(model(G_S, t));
                got = sample(1);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin errors++; $display("FAIL mid_restart t=%0d got %h exp %h", t, got, exp); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_pipe3();
        obs_t got, exp, prev;
        int t_x640 = -1, t_von = -1, t_x656 = -1, t_hsf = -1;
        int t_wrap[2] = '{-1, -1};
        int nwrap = 0;
        apply_reset();
        prev = sample(2);
        for (int t = 0; t < 3300; t++) begin
            exp_q.push_back(model(G_P3, t));
            got = sample(2);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin errors++; $display("FAIL pipe3 t=%0d got %h exp %h", t, got, exp); end
            if (t > 0) begin
                if (t_x640 < 0 && prev.x == 10'd639 && got.x == 10'd640) t_x640 = t;
                if (t_x656 < 0 && prev.x == 10'd655 && got.x == 10'd656) t_x656 = t;
                if (t_von < 0 && prev.von && !got.von) t_von = t;
                if (t_hsf < 0 && prev.hs && !got.hs) t_hsf = t;
                if (prev.x == 10'd799 && got.x == 10'd0) begin
                    if (nwrap < 2) t_wrap[nwrap] = t;
                    nwrap++;
                end
            end
            prev = got;
            @(posedge clk); #1;
        end
        checks++;
        if (t_von - t_x640 != 6) begin errors++; $display("FAIL p3_von_lag got %0d exp 6", t_von - t_x640); end
        checks++;
        if (t_hsf - t_x656 != 6) begin errors++; $display("FAIL p3_hsync_lag got %0d exp 6", t_hsf - t_x656); end
        checks++;
        if (t_wrap[1] - t_wrap[0] != 1600) begin errors++; $display("FAIL p3_line_period got %0d exp 1600", t_wrap[1] - t_wrap[0]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        test_reset();
        test_horizontal();
        test_vertical();
        test_frame();
        test_mid_reset();
        test_pipe3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
